wb_sk6812_rx: RTL
=================

Name: wb_sk6812_rx

Overview:
- Wishbone slave that decodes an SK6812RGBW single-wire NRZ stream back into 32-bit GRBW words.
- Used for loopback self-test of the LED transmitter peripheral, and for monitoring the DOUT of the last LED in a chain.
- Decoded words are buffered in a small FIFO and read by the CPU over Wishbone.
- Same register style and ack discipline as the other wb_ peripherals.

Parameters:
- BIT_THRESH, 23: high-time in clk cycles at or above which a bit decodes as 1 (about 0.46 us at 50 MHz).
- MIN_HIGH, 5: high pulses shorter than this are treated as glitches and ignored.
- RESET_CYCLES, 4000: low-time in cycles that marks end of frame (80 us at 50 MHz).
- FIFO_AW, 4: FIFO address width; depth is 2^FIFO_AW words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_stb_i  in  1  Wishbone strobe
- wb_cyc_i  in  1  Wishbone cycle
- wb_ack_o  out  1  Wishbone acknowledge
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  32  Wishbone address; decode uses [15:0]
- wb_sel_i  in  4  byte selects; ignored, full-word access only
- wb_dat_i  in  32  Wishbone write data
- wb_dat_o  out  32  Wishbone read data, registered
- led_din  in  1  asynchronous serial input

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous and active-high. Reset values: wb_dat_o=0, ack=0, enable=0, FIFO empty, all sticky flags 0, FSM in WAIT_GAP, counters 0.
- Wishbone:
  - wb_ack_o = stb & cyc & ack.
  - ack is registered; it is cleared every cycle and set for one cycle when (stb & cyc & ~ack). This gives 1-cycle latency and back-to-back accesses take 2 cycles each.
- Register map:
  - 0x0000 DATA (R): returns the FIFO head and pops it on the acked read. If the FIFO is empty, returns 0 with no pop.
  - 0x0004 STATUS (R): [FIFO_AW:0]=fill level, [16]=empty, [17]=full, [24]=frame_done, [25]=overflow, [26]=partial.
  - 0x0008 CTRL (R/W): bit0=enable. Writing bit1=1 flushes the FIFO and clears frame_done, overflow and partial; bit1 is self-clearing and reads as 0.
  - Other addresses: reads return 0, writes are ignored.
- Input path: led_din passes through a 2-flop synchronizer; rise/fall edges are detected on the synchronized signal.
- Counters: hcnt and lcnt are 16 bits, saturating. Bit counter is 5 bits. 32-bit shift register shifts MSB first, so G lands in [31:24] and W in [7:0].
- FSM:
  - WAIT_GAP: entered on reset, when enable=0, or after a flush. Counts low time; when lcnt reaches RESET_CYCLES, go to IDLE. Any high restarts the count. This prevents decoding from the middle of a frame.
  - IDLE: line low. On a rising edge, clear hcnt and go to HIGH. If lcnt reaches RESET_CYCLES with bitcnt != 0, set partial and clear bitcnt.
  - HIGH: increment hcnt. On a falling edge:
    - hcnt < MIN_HIGH: drop the pulse, state unchanged otherwise.
    - else shift in (hcnt >= BIT_THRESH) and increment bitcnt.
    - On the 32nd bit, push the word, reset bitcnt to 0 and set frame_done.
    - Clear lcnt and return to IDLE.
    - If hcnt saturates, treat it as line fault: go to WAIT_GAP and discard partial bits without setting partial.
- FIFO boundaries:
  - Push when full: word dropped, overflow set.
  - Push and pop in the same cycle: both take effect and the level is unchanged. When the FIFO is full, the simultaneous push is accepted.
  - A flush has priority over a same-cycle push.
- Sticky flags: set on events, cleared only by a CTRL flush or reset.
- Clearing enable mid-frame: go to WAIT_GAP at once and discard the partial word; the FIFO contents are kept.

Decomposition:
- Package sk6812_rx_pkg holds:
  - register offsets DATA/STATUS/CTRL;
  - STATUS and CTRL bit indices;
  - FSM state encoding: WAIT_GAP, IDLE, HIGH.
- Sub-module sk6812_rx_fifo: synchronous FIFO, parameterised width and depth, with push, pop, flush, full, empty and level, and a first-word-fall-through head.

Test Plan:
- Reset, enable=1, line low for 4000 cycles, then send 0xA55A0FF0 (1 = 30 high/20 low, 0 = 15 high/35 low), then 4000 low -> STATUS level=1 and frame_done=1; DATA reads 0xA55A0FF0; then level=0 and empty=1.
- Enable while the line is mid-frame (bits already toggling) -> no words pushed until a 4000-cycle low gap, then the following frame decodes correctly.
- Send 17 words with no reads -> level=16, full=1, overflow=1; the first 16 words are read back in order, and the 17th is lost.
- Send 20 bits, then a 4000-cycle low gap -> partial=1, FIFO unchanged; the next full word decodes correctly.
- Insert a 3-cycle high glitch between bits of a word -> the word decodes unchanged. A read of DATA when empty -> 0. Write CTRL=0x3 -> all flags clear and level=0.
- Apply reset mid-HIGH -> next cycle wb_dat_o=0, FIFO empty, flags 0, FSM in WAIT_GAP; Wishbone ack is exactly one cycle per access.

Source files
------------

// File: rtl/sk6812_rx_pkg.sv
// Shared register offsets, bit positions and FSM encoding for the SK6812 RGBW receiver.
package sk6812_rx_pkg;

  localparam logic [15:0] ADDR_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_CTRL   = 16'h0008;

  localparam int STAT_EMPTY      = 16;
  localparam int STAT_FULL       = 17;
  localparam int STAT_FRAME_DONE = 24;
  localparam int STAT_OVERFLOW   = 25;
  localparam int STAT_PARTIAL    = 26;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam logic [1:0] ST_WAIT_GAP = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sk6812_rx_fifo.sv
// Synchronous FIFO with first-word-fall-through head, flush and fill level.
module sk6812_rx_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wptr] <= din;
  end

endmodule

// File: rtl/wb_sk6812_rx.sv
// Wishbone slave decoding an SK6812 RGBW NRZ stream into 32-bit GRBW words.
//
// state     | meaning
// WAIT_GAP  | waiting for a full reset-length low gap before trusting bit boundaries
// IDLE      | line low between bits; watches for the frame-end gap
// HIGH      | measuring the high time of the current pulse
module wb_sk6812_rx
  import sk6812_rx_pkg::*;
#(
  parameter int BIT_THRESH   = 23,
  parameter int MIN_HIGH     = 5,
  parameter int RESET_CYCLES = 4000,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        led_din
);

  localparam logic [15:0] GAP_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] HI_THRESH = 16'(BIT_THRESH);
  localparam logic [15:0] HI_MIN    = 16'(MIN_HIGH);

  logic        din_s0, din_s1, din_d;
  logic        rise, fall;
  logic [1:0]  state;
  logic [15:0] hcnt, lcnt;
  logic [4:0]  bitcnt;
  logic [31:0] shreg;
  logic        enable, frame_done, overflow, partial;
  logic        ack;
  logic        access, flush, pop, push, drop, gap_hit, set_partial, bit_val;
  logic [15:0] adr;
  logic [31:0] push_word, rdata, fifo_dout;
  logic        fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:16], wb_dat_i[31:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      din_s0 <= 1'b0;
      din_s1 <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      din_s0 <= led_din;
      din_s1 <= din_s0;
      din_d  <= din_s1;
    end
  end

  assign rise = din_s1 & ~din_d;
  assign fall = ~din_s1 & din_d;

  assign adr      = wb_adr_i[15:0];
  assign access   = wb_stb_i & wb_cyc_i & ~ack;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
  assign flush    = access & wb_we_i & (adr == ADDR_CTRL) & wb_dat_i[CTRL_FLUSH];
  assign pop      = access & ~wb_we_i & (adr == ADDR_DATA);

  assign bit_val     = (hcnt >= HI_THRESH);
  assign push_word   = {shreg[30:0], bit_val};
  assign push        = enable & (state == ST_HIGH) & fall & (hcnt >= HI_MIN) & (bitcnt == 5'd31);
  assign drop        = push & fifo_full & ~pop;
  assign gap_hit     = ~din_s1 & (lcnt >= GAP_LAST);
  assign set_partial = enable & (state == ST_IDLE) & gap_hit & (bitcnt != 5'd0);

  sk6812_rx_fifo #(.W(32), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    rdata = '0;
    case (adr)
      ADDR_DATA:   if (!fifo_empty) rdata = fifo_dout;
      ADDR_STATUS: begin
        rdata[FIFO_AW:0]       = fifo_level;
        rdata[STAT_EMPTY]      = fifo_empty;
        rdata[STAT_FULL]       = fifo_full;
        rdata[STAT_FRAME_DONE] = frame_done;
        rdata[STAT_OVERFLOW]   = overflow;
        rdata[STAT_PARTIAL]    = partial;
      end
      ADDR_CTRL:   rdata[CTRL_ENABLE] = enable;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= 1'b0;
      wb_dat_o <= '0;
      enable   <= 1'b0;
    end else begin
      ack <= access;
      if (access && !wb_we_i) wb_dat_o <= rdata;
      if (access && wb_we_i && adr == ADDR_CTRL) enable <= wb_dat_i[CTRL_ENABLE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
    end else begin
      if (push)        frame_done <= 1'b1;
      if (drop)        overflow   <= 1'b1;
      if (set_partial) partial    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_WAIT_GAP;
      hcnt   <= '0;
      lcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (!enable || flush) begin
      state  <= ST_WAIT_GAP;
      lcnt   <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        ST_WAIT_GAP: begin
          if (din_s1) begin
            lcnt <= '0;
          end else begin
            lcnt <= sat_inc16(lcnt);
            if (lcnt >= GAP_LAST) state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            hcnt  <= '0;
            state <= ST_HIGH;
          end else begin
            lcnt <= sat_inc16(lcnt);
            if (gap_hit && bitcnt != 5'd0) bitcnt <= '0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_IDLE;
            // Short pulses are glitches: leave the partial word untouched.
            if (hcnt >= HI_MIN) begin
              shreg  <= push_word;
              bitcnt <= bitcnt + 5'd1;
              lcnt   <= '0;
            end
          end else if (hcnt == 16'hFFFF) begin
            state  <= ST_WAIT_GAP;
            lcnt   <= '0;
            bitcnt <= '0;
          end else begin
            hcnt <= hcnt + 16'd1;
          end
        end
        default: state <= ST_WAIT_GAP;
      endcase
    end
  end

endmodule
